// File: rtl/cussen_repeat.sv
// Nine-entry byte sorter: load, nine odd-even transposition passes, publish the
// sorted vector and scalar times distinct-count. Free-running, 11 clocks per frame.

module cussen_cswap (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] lo,
  output logic [7:0] hi
);
  // Equal values pass straight through (no swap).
  assign lo = (a > b) ? b : a;
  assign hi = (a > b) ? a : b;
endmodule

module cussen_repeat (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  input  logic [7:0] in8,
  input  logic [7:0] in9,
  input  logic [7:0] scalar,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4,
  output logic [7:0] out5,
  output logic [7:0] out6,
  output logic [7:0] out7,
  output logic [7:0] out8,
  output logic [7:0] out9,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SORT    = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [8:0][7:0]  w_q, w_d;
  logic [8:0][7:0]  out_q, out_d;
  logic [7:0]       scalar_q, scalar_d;
  logic [7:0]       product_q, product_d;
  logic [3:0]       pass_q, pass_d;

  logic [7:0][7:0]  lo, hi;
  logic [3:0]       distinct;
  logic [7:0]       scaled;

  // One comparator per adjacent pair; each pass picks the odd or even subset.
  for (genvar i = 0; i < 8; i++) begin : g_cs
    cussen_cswap u_cs (
      .a  (w_q[i]),
      .b  (w_q[i+1]),
      .lo (lo[i]),
      .hi (hi[i])
    );
  end

  always_comb begin
    distinct = 4'd1;
    for (int i = 0; i < 8; i++)
      if (w_q[i] != w_q[i+1]) distinct = distinct + 4'd1;
  end

  // 8-bit context keeps only the low byte of the product.
  assign scaled = scalar_q * {4'd0, distinct};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:    state_d = ST_SORT;
      ST_SORT:    if (pass_q == 4'd8) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = ST_LOAD;
      default:    state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    w_d       = w_q;
    out_d     = out_q;
    scalar_d  = scalar_q;
    product_d = product_q;
    pass_d    = pass_q;
    case (state_q)
      ST_LOAD: begin
        w_d      = {in9, in8, in7, in6, in5, in4, in3, in2, in1};
        scalar_d = scalar;
        pass_d   = 4'd0;
      end
      ST_SORT: begin
        // pass_q counts completed passes, so even pass_q means an odd pass.
        if (!pass_q[0]) begin
          for (int i = 0; i < 8; i += 2) begin
            w_d[i]   = lo[i];
            w_d[i+1] = hi[i];
          end
        end else begin
          for (int i = 1; i < 8; i += 2) begin
            w_d[i]   = lo[i];
            w_d[i+1] = hi[i];
          end
        end
        pass_d = pass_q + 4'd1;
      end
      ST_PUBLISH: begin
        out_d     = w_q;
        product_d = scaled;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q       <= '0;
      out_q     <= '0;
      scalar_q  <= '0;
      product_q <= '0;
      pass_q    <= '0;
    end else begin
      w_q       <= w_d;
      out_q     <= out_d;
      scalar_q  <= scalar_d;
      product_q <= product_d;
      pass_q    <= pass_d;
    end
  end

  assign out1    = out_q[0];
  assign out2    = out_q[1];
  assign out3    = out_q[2];
  assign out4    = out_q[3];
  assign out5    = out_q[4];
  assign out6    = out_q[5];
  assign out7    = out_q[6];
  assign out8    = out_q[7];
  assign out9    = out_q[8];
  assign product = product_q;

endmodule

// File: tb/tb_cussen_repeat.sv
// Directed bench for cussen_repeat: hand-computed sorted vectors and products
// per frame, plus hold, mid-frame input change and mid-frame reset cases.

module tb_cussen_repeat;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in1, in2, in3, in4, in5, in6, in7, in8, in9, scalar;
  logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8, out9, product;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  cussen_repeat dut (
    .clk(clk), .rst(rst),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .in6(in6), .in7(in7), .in8(in8), .in9(in9), .scalar(scalar),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .out6(out6), .out7(out7), .out8(out8), .out9(out9), .product(product)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] a, b, c, d, e, f, g, h, i, s);
    in1 = a; in2 = b; in3 = c; in4 = d; in5 = e;
    in6 = f; in7 = g; in8 = h; in9 = i; scalar = s;
  endtask

  function automatic logic [71:0] outs();
    return {out1, out2, out3, out4, out5, out6, out7, out8, out9};
  endfunction

  // Called at a negedge just before a LOAD edge; leaves us just before the next LOAD.
  task automatic frame(input string tag, input logic [71:0] old_v, input logic [7:0] old_p,
                       input logic [71:0] exp_v, input logic [7:0] exp_p);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk({tag, "_hold"}, outs(), old_v);
    chk({tag, "_hold_p"}, {64'd0, product}, {64'd0, old_p});
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_out"}, outs(), exp_v);
    chk({tag, "_p"}, {64'd0, product}, {64'd0, exp_p});
  endtask

  localparam logic [71:0] V1 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd9};
  localparam logic [71:0] V2 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  localparam logic [71:0] V3 = {9{8'd5}};
  localparam logic [71:0] V4 = {9{8'd255}};
  localparam logic [71:0] V5 = {8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9};
  localparam logic [71:0] VA = {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd7, 8'd7};
  localparam logic [71:0] VB = {8'd0, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128, 8'd255};
  localparam logic [71:0] VC = {8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", outs(), 72'd0);
    chk("rst_p", {64'd0, product}, 72'd0);

    rst = 1'b0;
    set_in(9, 1, 0, 0, 0, 0, 0, 0, 0, 6);
    frame("f1", 72'd0, 8'd0, V1, 8'd18);

    set_in(9, 8, 7, 6, 5, 4, 3, 2, 1, 2);
    frame("f2", V1, 8'd18, V2, 8'd18);

    set_in(5, 5, 5, 5, 5, 5, 5, 5, 5, 37);
    frame("f3", V2, 8'd18, V3, 8'd37);

    set_in(255, 255, 255, 255, 255, 255, 255, 255, 255, 0);
    frame("f4", V3, 8'd37, V4, 8'd0);

    set_in(3, 1, 4, 1, 5, 9, 2, 6, 8, 200);
    frame("f5", V4, 8'd0, V5, 8'd64);

    // Inputs change mid-SORT: frame A publishes, B follows one frame later.
    set_in(7, 7, 3, 3, 0, 0, 1, 1, 2, 10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    set_in(255, 0, 128, 64, 32, 16, 8, 4, 2, 3);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("fa_out", outs(), VA);
    chk("fa_p", {64'd0, product}, {64'd0, 8'd50});
    frame("fb", VA, 8'd50, VB, 8'd27);

    // Reset mid-SORT clears outputs; the next edge starts a fresh frame.
    set_in(2, 2, 2, 2, 2, 2, 2, 2, 1, 255);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_out", outs(), 72'd0);
    chk("mrst_p", {64'd0, product}, 72'd0);
    frame("fc", 72'd0, 8'd0, VC, 8'd254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
